// File: rtl/rgb_color_sequencer_if.sv
// AXI4-Lite channel bundle between the colour sequencer and the RGB controller.
// The master modport faces the sequencer; the slave modport faces the controller.
interface rgb_color_sequencer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   AWADDR;
    logic [2:0]      AWPROT;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic [2:0]      ARPROT;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID,
        output BREADY, ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY,
        input  RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID,
        input  BREADY, ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY,
        output RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/rgb_color_sequencer.sv
// AXI4-Lite master cycling the RGB controller through a local colour table:
// write R/G/B/commit, read back R/G/B, hold, advance with wrap.
module rgb_color_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
    parameter int C_NUM_ENTRIES = 4,
    parameter int C_HOLD_CYCLES = 1000,
    localparam int IW = $clog2(C_NUM_ENTRIES)
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tbl_we,
    input  logic [IW-1:0]         tbl_addr,
    input  logic [23:0]           tbl_wdata,
    output logic                  busy,
    output logic                  error,
    output logic [IW-1:0]         entry_idx,
    rgb_color_sequencer_if.master M_AXI
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int HW = $clog2(C_HOLD_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(C_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_HOLD
    } state_t;

    state_t            r_state, w_state_n;
    logic [1:0]        r_k, w_k_n;
    logic [23:0]       r_color, w_color_n;
    logic [IW-1:0]     r_idx, w_idx_n;
    logic [HW-1:0]     r_hold, w_hold_n;
    logic              r_busy, w_busy_n;
    logic              r_error, w_error_n;
    logic              r_stop_pend, w_stop_pend_n;
    logic              r_awvalid, w_awvalid_n;
    logic              r_wvalid, w_wvalid_n;
    logic              r_bready, w_bready_n;
    logic              r_arvalid, w_arvalid_n;
    logic              r_rready, w_rready_n;
    logic [AW-1:0]     r_awaddr, w_awaddr_n;
    logic [AW-1:0]     r_araddr, w_araddr_n;
    logic [DW-1:0]     r_wdata, w_wdata_n;
    logic [DW/8-1:0]   r_wstrb, w_wstrb_n;
    logic              w_issue_wr, w_issue_rd, w_stop_req;
    logic              w_aw_fin, w_w_fin;
    logic [23:0]       r_table [C_NUM_ENTRIES];

    function automatic logic [AW-1:0] f_addr(input logic [1:0] k);
        return C_BASE_ADDR + {{(AW-4){1'b0}}, k, 2'b00};
    endfunction

    function automatic logic [DW-1:0] f_word(input logic [23:0] c,
                                             input logic [1:0]  k);
        logic [DW-1:0] w;
        unique case (k)
            2'd0:    w = {{(DW-8){1'b0}}, c[23:16]};
            2'd1:    w = {{(DW-8){1'b0}}, c[15:8]};
            2'd2:    w = {{(DW-8){1'b0}}, c[7:0]};
            default: w = DW'(1);
        endcase
        return w;
    endfunction

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < C_NUM_ENTRIES; i++) r_table[i] <= '0;
        end else if (tbl_we) begin
            r_table[tbl_addr] <= tbl_wdata;
        end
    end

    assign w_aw_fin   = !r_awvalid || M_AXI.AWREADY;
    assign w_w_fin    = !r_wvalid || M_AXI.WREADY;
    assign w_stop_req = r_stop_pend || stop;

    always_comb begin
        w_state_n   = r_state;
        w_k_n       = r_k;
        w_color_n   = r_color;
        w_idx_n     = r_idx;
        w_hold_n    = r_hold;
        w_busy_n    = r_busy;
        w_error_n   = r_error;
        w_awvalid_n = r_awvalid;
        w_wvalid_n  = r_wvalid;
        w_bready_n  = r_bready;
        w_arvalid_n = r_arvalid;
        w_rready_n  = r_rready;
        w_awaddr_n  = r_awaddr;
        w_araddr_n  = r_araddr;
        w_wdata_n   = r_wdata;
        w_wstrb_n   = r_wstrb;
        w_issue_wr  = 1'b0;
        w_issue_rd  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_error_n  = 1'b0;
                    w_busy_n   = 1'b1;
                    w_idx_n    = '0;
                    w_color_n  = r_table[0];
                    w_k_n      = 2'd0;
                    w_issue_wr = 1'b1;
                end
            end
            S_WR_REQ: begin
                if (M_AXI.AWREADY) w_awvalid_n = 1'b0;
                if (M_AXI.WREADY)  w_wvalid_n  = 1'b0;
                if (w_aw_fin && w_w_fin) begin
                    w_state_n  = S_WR_RESP;
                    w_bready_n = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (M_AXI.BVALID) begin
                    w_bready_n = 1'b0;
                    if (M_AXI.BRESP != 2'b00) begin
                        w_state_n = S_IDLE;
                        w_busy_n  = 1'b0;
                        w_error_n = 1'b1;
                    end else if (r_k == 2'd3) begin
                        w_k_n      = 2'd0;
                        w_issue_rd = 1'b1;
                    end else begin
                        w_k_n      = r_k + 2'd1;
                        w_issue_wr = 1'b1;
                    end
                end
            end
            S_RD_REQ: begin
                if (M_AXI.ARREADY) begin
                    w_arvalid_n = 1'b0;
                    w_rready_n  = 1'b1;
                    w_state_n   = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (M_AXI.RVALID) begin
                    w_rready_n = 1'b0;
                    if (M_AXI.RRESP != 2'b00 ||
                        M_AXI.RDATA != f_word(r_color, r_k)) begin
                        w_state_n = S_IDLE;
                        w_busy_n  = 1'b0;
                        w_error_n = 1'b1;
                    end else if (r_k != 2'd2) begin
                        w_k_n      = r_k + 2'd1;
                        w_issue_rd = 1'b1;
                    end else if (w_stop_req) begin
                        w_state_n = S_IDLE;
                        w_busy_n  = 1'b0;
                    end else begin
                        w_state_n = S_HOLD;
                        w_hold_n  = HOLD_LD;
                    end
                end
            end
            S_HOLD: begin
                if (w_stop_req) begin
                    w_state_n = S_IDLE;
                    w_busy_n  = 1'b0;
                end else if (r_hold == '0) begin
                    w_idx_n    = r_idx + IW'(1);
                    w_color_n  = r_table[w_idx_n];
                    w_k_n      = 2'd0;
                    w_issue_wr = 1'b1;
                end else begin
                    w_hold_n = r_hold - HW'(1);
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        // Request launch shared by start, next-register and next-entry paths
        if (w_issue_wr) begin
            w_state_n   = S_WR_REQ;
            w_awvalid_n = 1'b1;
            w_wvalid_n  = 1'b1;
            w_awaddr_n  = f_addr(w_k_n);
            w_wdata_n   = f_word(w_color_n, w_k_n);
            w_wstrb_n   = '1;
        end
        if (w_issue_rd) begin
            w_state_n   = S_RD_REQ;
            w_arvalid_n = 1'b1;
            w_araddr_n  = f_addr(w_k_n);
        end
        w_stop_pend_n = (w_state_n != S_IDLE) &&
                        (r_stop_pend || (stop && r_busy));
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_color     <= '0;
            r_idx       <= '0;
            r_hold      <= '0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
        end else begin
            r_state     <= w_state_n;
            r_k         <= w_k_n;
            r_color     <= w_color_n;
            r_idx       <= w_idx_n;
            r_hold      <= w_hold_n;
            r_busy      <= w_busy_n;
            r_error     <= w_error_n;
            r_stop_pend <= w_stop_pend_n;
            r_awvalid   <= w_awvalid_n;
            r_wvalid    <= w_wvalid_n;
            r_bready    <= w_bready_n;
            r_arvalid   <= w_arvalid_n;
            r_rready    <= w_rready_n;
            r_awaddr    <= w_awaddr_n;
            r_araddr    <= w_araddr_n;
            r_wdata     <= w_wdata_n;
            r_wstrb     <= w_wstrb_n;
        end
    end

    assign busy          = r_busy;
    assign error         = r_error;
    assign entry_idx     = r_idx;
    assign M_AXI.AWADDR  = r_awaddr;
    assign M_AXI.AWPROT  = 3'b000;
    assign M_AXI.AWVALID = r_awvalid;
    assign M_AXI.WDATA   = r_wdata;
    assign M_AXI.WSTRB   = r_wstrb;
    assign M_AXI.WVALID  = r_wvalid;
    assign M_AXI.BREADY  = r_bready;
    assign M_AXI.ARADDR  = r_araddr;
    assign M_AXI.ARPROT  = 3'b000;
    assign M_AXI.ARVALID = r_arvalid;
    assign M_AXI.RREADY  = r_rready;
endmodule

// File: tb/tb_rgb_color_sequencer.sv
// Bench for rgb_color_sequencer: AXI4-Lite slave model with delay/fault knobs,
// random colour tables and a write/read transaction model per table visit.
module tb_rgb_color_sequencer;
    localparam int N  = 4;
    localparam int H  = 5;
    localparam int IW = 2;
    localparam logic [31:0] BASE = 32'hA000_0000;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          tbl_we = 1'b0;
    logic [IW-1:0] tbl_addr = '0;
    logic [23:0]   tbl_wdata = '0;
    logic          busy, error;
    logic [IW-1:0] entry_idx;

    rgb_color_sequencer_if #(.AW(32), .DW(32)) axi ();

    rgb_color_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
        .C_BASE_ADDR(BASE), .C_NUM_ENTRIES(N), .C_HOLD_CYCLES(H)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .stop(stop),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .busy(busy), .error(error), .entry_idx(entry_idx), .M_AXI(axi)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;
    logic [23:0] tbl_m [N];

    // Slave model knobs (written by the stimulus only)
    int aw_delay = 0, w_delay = 0;
    int err_wr_off = -1, bad_rd_off = -1;

    int          aw_wait, w_wait;
    logic        s_aw_ok, s_w_ok;
    logic [31:0] s_awaddr, s_wdata;
    logic [31:0] s_mem [4];
    logic [31:0] wa_q[$], wd_q[$], ra_q[$];
    int          es_cyc_q[$], es_idx_q[$];
    int          rhs_cnt = 0, viol = 0, b_hs_cyc = 0;
    logic        saw_split = 1'b0;
    logic        awv_prev, pend_aw, pend_w, pend_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    logic        w_aw_hs, w_w_hs;
    logic [31:0] w_a, w_d;
    assign axi.AWREADY = axi.AWVALID && !s_aw_ok && (aw_wait >= aw_delay);
    assign axi.WREADY  = axi.WVALID && !s_w_ok && (w_wait >= w_delay);
    assign axi.ARREADY = axi.ARVALID && !axi.RVALID;
    assign w_aw_hs = axi.AWVALID && axi.AWREADY;
    assign w_w_hs  = axi.WVALID && axi.WREADY;
    assign w_a = s_aw_ok ? s_awaddr : axi.AWADDR;
    assign w_d = s_w_ok ? s_wdata : axi.WDATA;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            axi.BVALID <= 1'b0; axi.BRESP <= 2'b00;
            axi.RVALID <= 1'b0; axi.RRESP <= 2'b00; axi.RDATA <= '0;
            s_aw_ok <= 1'b0; s_w_ok <= 1'b0;
            aw_wait <= 0; w_wait <= 0;
            for (int i = 0; i < 4; i++) s_mem[i] <= '0;
        end else begin
            aw_wait <= (axi.AWVALID && !w_aw_hs) ? aw_wait + 1 : 0;
            w_wait  <= (axi.WVALID && !w_w_hs) ? w_wait + 1 : 0;
            if (axi.BVALID && axi.BREADY) axi.BVALID <= 1'b0;
            if ((s_aw_ok || w_aw_hs) && (s_w_ok || w_w_hs)) begin
                wa_q.push_back(w_a);
                wd_q.push_back(w_d);
                s_mem[w_a[3:2]] <= w_d;
                axi.BVALID <= 1'b1;
                axi.BRESP <= ((w_a - BASE) == 32'(err_wr_off)) ? 2'b10 : 2'b00;
                s_aw_ok <= 1'b0;
                s_w_ok  <= 1'b0;
            end else begin
                if (w_aw_hs) begin s_aw_ok <= 1'b1; s_awaddr <= axi.AWADDR; end
                if (w_w_hs)  begin s_w_ok <= 1'b1;  s_wdata <= axi.WDATA;   end
            end
            if (axi.RVALID && axi.RREADY) axi.RVALID <= 1'b0;
            if (axi.ARVALID && axi.ARREADY) begin
                ra_q.push_back(axi.ARADDR);
                axi.RVALID <= 1'b1;
                axi.RRESP  <= 2'b00;
                axi.RDATA  <= ((axi.ARADDR - BASE) == 32'(bad_rd_off)) ?
                              32'h11 : s_mem[axi.ARADDR[3:2]];
            end
        end
    end

    // Transaction monitor: entry starts, handshakes and VALID stability
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awv_prev <= 1'b0; pend_aw <= 1'b0; pend_w <= 1'b0; pend_ar <= 1'b0;
        end else begin
            awv_prev <= axi.AWVALID;
            if (axi.AWVALID && !awv_prev && axi.AWADDR == BASE) begin
                es_cyc_q.push_back(cyc);
                es_idx_q.push_back(int'(entry_idx));
            end
            if (axi.BVALID && axi.BREADY) b_hs_cyc <= cyc;
            if (axi.RVALID && axi.RREADY) rhs_cnt <= rhs_cnt + 1;
            if (axi.AWVALID && !axi.WVALID) saw_split <= 1'b1;
            viol <= viol
                + ((pend_aw && (!axi.AWVALID || axi.AWADDR != p_awaddr)) ? 1 : 0)
                + ((pend_w && (!axi.WVALID || axi.WDATA != p_wdata)) ? 1 : 0)
                + ((pend_ar && (!axi.ARVALID || axi.ARADDR != p_araddr)) ? 1 : 0);
            pend_aw <= axi.AWVALID && !axi.AWREADY; p_awaddr <= axi.AWADDR;
            pend_w  <= axi.WVALID && !axi.WREADY;   p_wdata  <= axi.WDATA;
            pend_ar <= axi.ARVALID && !axi.ARREADY; p_araddr <= axi.ARADDR;
        end
    end

    function automatic logic [31:0] exp_word(input logic [23:0] c, input int k);
        if (k == 3) return 32'h1;
        return (32'(c) >> (8 * (2 - k))) & 32'hFF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset;
        ARESETN = 1'b0;
        tick(3);
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic load_table(input logic [23:0] first);
        for (int i = 0; i < N; i++) begin
            logic [23:0] c;
            c = (i == 0) ? first : 24'($urandom);
            if (c[23:16] == 8'h11) c[23:16] = 8'h12;
            @(negedge ACLK);
            tbl_we = 1'b1; tbl_addr = IW'(i); tbl_wdata = c;
            tbl_m[i] = c;
        end
        @(negedge ACLK);
        tbl_we = 1'b0;
    endtask

    task automatic pulse(input logic st, input logic sp);
        @(negedge ACLK);
        start = st; stop = sp;
        @(posedge ACLK);
        #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_idle(input int lim, output bit ok, output int fall);
        ok = 1'b0; fall = -1;
        for (int i = 0; i < lim; i++) begin
            tick(1);
            if (!busy) begin ok = 1'b1; fall = cyc; break; end
        end
    endtask

    task automatic wait_es(input int n, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick(1);
            if (es_cyc_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        logic [190:0] v;
        do_reset;
        tick(1);
        v = {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY,
             axi.AWADDR, axi.WDATA, axi.WSTRB, axi.ARADDR, axi.AWPROT,
             axi.ARPROT, busy, error, entry_idx, 52'h0, 32'h0};
        n_total++;
        if (v !== '0) $display("FAIL reset_outputs: got %0h expected 0", v);
        else n_pass++;
    endtask

    task automatic test_basic;
        int w0, r0, e0, s, fall;
        bit ok;
        load_table(24'h102030);
        w0 = wa_q.size(); r0 = ra_q.size(); e0 = es_cyc_q.size();
        pulse(1'b1, 1'b0);
        s = cyc;
        n_total++;
        if ({axi.AWVALID, axi.WVALID, busy} !== 3'b111)
            $display("FAIL first_req: got %b expected 111",
                     {axi.AWVALID, axi.WVALID, busy});
        else n_pass++;
        wait_es(e0 + 5, 200, ok);
        n_total++;
        if (!ok) $display("FAIL entry_visits: got %0d expected 5", es_cyc_q.size() - e0);
        else n_pass++;
        pulse(1'b0, 1'b1);
        wait_idle(100, ok, fall);
        n_total++;
        if (!ok || wa_q.size() - w0 != 20 || ra_q.size() - r0 != 15)
            $display("FAIL stop_counts: got w=%0d r=%0d expected w=20 r=15",
                     wa_q.size() - w0, ra_q.size() - r0);
        else n_pass++;
        n_total++;
        if (es_cyc_q.size() > e0 && es_cyc_q[e0] !== s)
            $display("FAIL first_aw_cycle: got %0d expected %0d", es_cyc_q[e0], s);
        else n_pass++;
        for (int i = 0; i < 5 && e0 + i < es_cyc_q.size(); i++) begin
            n_total++;
            if (es_idx_q[e0 + i] !== i % N)
                $display("FAIL entry_idx[%0d]: got %0d expected %0d",
                         i, es_idx_q[e0 + i], i % N);
            else n_pass++;
            if (i > 0) begin
                n_total++;
                if (es_cyc_q[e0 + i] - es_cyc_q[e0 + i - 1] !== 14 + H)
                    $display("FAIL entry_period[%0d]: got %0d expected %0d", i,
                             es_cyc_q[e0 + i] - es_cyc_q[e0 + i - 1], 14 + H);
                else n_pass++;
            end
        end
        for (int i = 0; i < 20 && w0 + i < wa_q.size(); i++) begin
            logic [23:0] c;
            c = tbl_m[(i / 4) % N];
            n_total++;
            if (wa_q[w0 + i] !== BASE + 32'(4 * (i % 4)) ||
                wd_q[w0 + i] !== exp_word(c, i % 4))
                $display("FAIL write[%0d]: got %0h=%0h expected %0h=%0h", i,
                         wa_q[w0 + i], wd_q[w0 + i], BASE + 32'(4 * (i % 4)),
                         exp_word(c, i % 4));
            else n_pass++;
        end
        for (int i = 0; i < 15 && r0 + i < ra_q.size(); i++) begin
            n_total++;
            if (ra_q[r0 + i] !== BASE + 32'(4 * (i % 3)))
                $display("FAIL read_addr[%0d]: got %0h expected %0h", i,
                         ra_q[r0 + i], BASE + 32'(4 * (i % 3)));
            else n_pass++;
        end
        n_total++;
        if (error !== 1'b0) $display("FAIL basic_error: got %b expected 0", error);
        else n_pass++;
    endtask

    task automatic test_stop_hold;
        int w0, r0, base_r;
        bit ok;
        load_table(24'($urandom));
        w0 = wa_q.size(); base_r = rhs_cnt;
        pulse(1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (rhs_cnt - base_r >= 3) begin ok = 1'b1; break; end
        end
        pulse(1'b0, 1'b1);
        n_total++;
        if (!ok || busy !== 1'b0)
            $display("FAIL stop_in_hold: got busy=%b ok=%b expected busy=0", busy, ok);
        else n_pass++;
        r0 = ra_q.size();
        tick(30);
        n_total++;
        if (wa_q.size() - w0 != 4 || ra_q.size() != r0 || error !== 1'b0)
            $display("FAIL after_stop: got w=%0d err=%b expected w=4 err=0",
                     wa_q.size() - w0, error);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int w0, fall;
        bit ok;
        load_table(24'($urandom));
        aw_delay = 3; w_delay = 1;
        w0 = wa_q.size();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_idle(150, ok, fall);
        aw_delay = 0; w_delay = 0;
        n_total++;
        if (!ok || wa_q.size() - w0 != 4)
            $display("FAIL bp_writes: got %0d expected 4", wa_q.size() - w0);
        else n_pass++;
        for (int k = 0; k < 4 && w0 + k < wa_q.size(); k++) begin
            n_total++;
            if (wa_q[w0 + k] !== BASE + 32'(4 * k) ||
                wd_q[w0 + k] !== exp_word(tbl_m[0], k))
                $display("FAIL bp_write[%0d]: got %0h=%0h expected %0h=%0h", k,
                         wa_q[w0 + k], wd_q[w0 + k], BASE + 32'(4 * k),
                         exp_word(tbl_m[0], k));
            else n_pass++;
        end
        n_total++;
        if (saw_split !== 1'b1)
            $display("FAIL bp_wvalid_drop: got %b expected 1", saw_split);
        else n_pass++;
        n_total++;
        if (viol !== 0) $display("FAIL valid_stability: got %0d expected 0", viol);
        else n_pass++;
    endtask

    task automatic test_bresp_err;
        int w0, r0, fall;
        bit ok;
        load_table(24'($urandom));
        err_wr_off = 4;
        w0 = wa_q.size(); r0 = ra_q.size();
        pulse(1'b1, 1'b0);
        wait_idle(100, ok, fall);
        n_total++;
        if (!ok || error !== 1'b1 || fall !== b_hs_cyc + 1)
            $display("FAIL bresp_fault: got err=%b fall=%0d expected err=1 fall=%0d",
                     error, fall, b_hs_cyc + 1);
        else n_pass++;
        tick(20);
        n_total++;
        if (wa_q.size() - w0 != 2 || ra_q.size() != r0 || axi.AWVALID !== 1'b0)
            $display("FAIL bresp_quiet: got w=%0d r=%0d expected w=2 r=0",
                     wa_q.size() - w0, ra_q.size() - r0);
        else n_pass++;
        err_wr_off = -1;
        pulse(1'b1, 1'b0);
        n_total++;
        if (error !== 1'b0 || busy !== 1'b1)
            $display("FAIL restart_clears: got err=%b busy=%b expected 0/1", error, busy);
        else n_pass++;
        pulse(1'b0, 1'b1);
        wait_idle(100, ok, fall);
    endtask

    task automatic test_rdata_err;
        int w0, r0, fall;
        bit ok;
        load_table(24'h10_5A_A5);
        bad_rd_off = 0;
        w0 = wa_q.size(); r0 = ra_q.size();
        pulse(1'b1, 1'b0);
        wait_idle(100, ok, fall);
        bad_rd_off = -1;
        n_total++;
        if (!ok || error !== 1'b1 || wa_q.size() - w0 != 4 || ra_q.size() - r0 != 1)
            $display("FAIL rdata_fault: got err=%b w=%0d r=%0d expected 1/4/1",
                     error, wa_q.size() - w0, ra_q.size() - r0);
        else n_pass++;
        pulse(1'b1, 1'b1);
        tick(2);
        n_total++;
        if (busy !== 1'b0 || axi.AWVALID !== 1'b0 || error !== 1'b1)
            $display("FAIL start_stop_ignored: got busy=%b err=%b expected 0/1",
                     busy, error);
        else n_pass++;
    endtask

    task automatic test_tbl_update;
        int w0, e0, fall;
        bit ok;
        logic [23:0] nc;
        load_table(24'($urandom));
        nc = tbl_m[0] ^ 24'h5A_3C_0F;
        w0 = wa_q.size(); e0 = es_cyc_q.size();
        pulse(1'b1, 1'b0);
        @(negedge ACLK);
        tbl_we = 1'b1; tbl_addr = '0; tbl_wdata = nc;
        @(negedge ACLK);
        tbl_we = 1'b0;
        wait_es(e0 + 5, 200, ok);
        pulse(1'b0, 1'b1);
        wait_idle(100, ok, fall);
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (wa_q.size() < w0 + 20 || wd_q[w0 + k] !== exp_word(tbl_m[0], k) ||
                wd_q[w0 + 16 + k] !== exp_word(nc, k))
                $display("FAIL tbl_update[%0d]: got size %0d expected old/new words",
                         k, wa_q.size() - w0);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic [190:0] v;
        load_table(24'($urandom));
        aw_delay = 3;
        pulse(1'b1, 1'b0);
        #2 ARESETN = 1'b0;
        #1;
        v = {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY,
             axi.AWADDR, axi.WDATA, axi.WSTRB, axi.ARADDR, axi.AWPROT,
             axi.ARPROT, busy, error, entry_idx, 52'h0, 32'h0};
        n_total++;
        if (v !== '0) $display("FAIL reset_mid: got %0h expected 0", v);
        else n_pass++;
        aw_delay = 0;
        tick(2);
        @(negedge ACLK);
        ARESETN = 1'b1;
        tick(5);
        n_total++;
        if (busy !== 1'b0 || axi.AWVALID !== 1'b0)
            $display("FAIL after_reset_mid: got busy=%b expected 0", busy);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stop_hold;
        test_backpressure;
        test_bresp_err;
        test_rdata_err;
        test_tbl_update;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
